// File: rtl/state_queue_ctrl.sv
// Visited-state queue controller: linear queue over an external memory, where each push
// first scans the stored set for a duplicate. Pops stream entries out in insertion order.
module state_queue_ctrl #(
  parameter int W  = 40,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic [W-1:0]  push_data,
  input  logic          pop_req,
  output logic [W-1:0]  pop_data,
  output logic          push_ack,
  output logic          push_dup,
  output logic          push_full,
  output logic          pop_ack,
  output logic          busy,
  output logic          empty,
  output logic [AW:0]   tail,
  output logic [39:0]   mem_addr,
  output logic [W-1:0]  mem_in,
  output logic          mem_we,
  input  logic [W-1:0]  mem_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

  state_t        r_state;
  logic [AW:0]   r_head;
  logic [AW:0]   r_tail;
  logic [AW:0]   r_idx;
  logic [W-1:0]  r_key;
  logic [W-1:0]  r_pop_data;
  logic          r_push_ack;
  logic          r_push_dup;
  logic          r_push_full;
  logic          r_pop_ack;

  logic          w_empty;
  logic          w_full;
  logic          w_pop_go;
  logic [AW:0]   w_idx;

  assign w_empty  = (r_head == r_tail);
  // tail reaches exactly 2**AW when every slot is used; the MSB alone flags it
  assign w_full   = r_tail[AW];
  assign w_pop_go = (r_state == S_IDLE) && pop_req && !w_empty;

  always_comb begin
    w_idx = r_head;
    case (r_state)
      S_SCAN:  w_idx = r_idx;
      S_WRITE: w_idx = r_tail;
      default: w_idx = r_head;
    endcase
  end

  assign mem_addr  = {{(40-AW-1){1'b0}}, w_idx};
  assign mem_in    = r_key;
  assign mem_we    = (r_state == S_WRITE) && !w_full;

  assign pop_data  = r_pop_data;
  assign pop_ack   = r_pop_ack;
  assign push_ack  = r_push_ack;
  assign push_dup  = r_push_dup;
  assign push_full = r_push_full;
  assign busy      = (r_state != S_IDLE);
  assign empty     = w_empty;
  assign tail      = r_tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_idx       <= '0;
      r_key       <= '0;
      r_pop_data  <= '0;
      r_push_ack  <= 1'b0;
      r_push_dup  <= 1'b0;
      r_push_full <= 1'b0;
      r_pop_ack   <= 1'b0;
    end else begin
      r_push_ack  <= 1'b0;
      r_push_dup  <= 1'b0;
      r_push_full <= 1'b0;
      r_pop_ack   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // a serviceable pop takes priority; the push waits for a later idle cycle
          if (w_pop_go) begin
            r_pop_data <= mem_out;
            r_pop_ack  <= 1'b1;
            r_head     <= r_head + 1'b1;
          end else if (push_req) begin
            r_key   <= push_data;
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_idx == r_tail) begin
            r_state <= S_WRITE;
          end else if (mem_out == r_key) begin
            r_push_ack <= 1'b1;
            r_push_dup <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WRITE: begin
          if (w_full) r_push_full <= 1'b1;
          else        r_tail      <= r_tail + 1'b1;
          r_push_ack <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/state_queue_ctrl.md
STATE_QUEUE_CTRL -- requirements
Module: state_queue_ctrl

Interface
REQ-001 SHALL have parameter W, default 40: width in bits of one stored puzzle state.
REQ-002 SHALL have parameter AW, default 8: index width; depth = 2**AW = 256 entries.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port push_req, input, 1: request to append push_data; level, held until push_ack.
REQ-006 SHALL have port push_data, input, W: state to append; sampled on acceptance.
REQ-007 SHALL have port pop_req, input, 1: request to read the next unprocessed state; level, held until pop_ack.
REQ-008 SHALL have port pop_data, output, W: popped state; valid while pop_ack=1; held otherwise.
REQ-009 SHALL have port push_ack, output, 1: one-cycle pulse when a push completes.
REQ-010 SHALL have port push_dup, output, 1: qualifies push_ack; 1 = state already stored, not written.
REQ-011 SHALL have port push_full, output, 1: qualifies push_ack; 1 = queue full, not written.
REQ-012 SHALL have port pop_ack, output, 1: one-cycle pulse when pop_data is valid.
REQ-013 SHALL have port busy, output, 1: high whenever FSM is not IDLE.
REQ-014 SHALL have port empty, output, 1: head == tail.
REQ-015 SHALL have port tail, output, AW+1: number of states ever stored (0..256).
REQ-016 SHALL have port mem_addr, output, 40: memory address; index zero-extended to 40 bits.
REQ-017 SHALL have port mem_in, output, W: memory write data.
REQ-018 SHALL have port mem_we, output, 1: memory write enable.
REQ-019 SHALL have port mem_out, input, W: memory read data, combinational from mem_addr (same cycle).

Function
REQ-020 SHALL implement a linear (non-wrapping) queue: entries 0..tail-1 form the visited set; head (AW+1 bits) marks the next entry to pop; entries are never overwritten.
REQ-021 SHALL have FSM states IDLE, SCAN, WRITE; IDLE is the only state in which requests are accepted.
REQ-022 IDLE, pop_req=1 and empty=0: SHALL drive mem_addr=head; at the clock edge pop_data<=mem_out, pop_ack<=1, head<=head+1; FSM stays IDLE (pop latency 1 cycle).
REQ-023 IDLE, pop_req=1 and empty=1: SHALL take no action; pop_ack stays 0 until a state is available.
REQ-024 IDLE, push_req=1, and pop not accepted this cycle: SHALL latch key<=push_data, idx<=0, go to SCAN.
REQ-025 Simultaneous push_req and serviceable pop_req in IDLE: pop SHALL win; push is accepted in a later IDLE cycle.
REQ-026 SCAN: SHALL drive mem_addr=idx; if idx==tail go to WRITE; else if mem_out==key (all W bits) pulse push_ack with push_dup=1 and go to IDLE; else idx<=idx+1.
REQ-027 WRITE, tail<256: SHALL drive mem_addr=tail, mem_in=key, mem_we=1 for exactly one cycle; tail<=tail+1; pulse push_ack (dup=0, full=0); go to IDLE.
REQ-028 WRITE, tail==256: SHALL not assert mem_we; pulse push_ack with push_full=1; go to IDLE.
REQ-029 Push latency SHALL be: non-dup = tail+3 cycles from acceptance edge to push_ack; dup at entry k = k+2 cycles.
REQ-030 mem_we SHALL be 0 in every state other than WRITE with tail<256.
REQ-031 push_dup and push_full SHALL be 0 whenever push_ack is 0.
REQ-032 push_req/push_data changes while busy=1 SHALL be ignored.
REQ-033 mem_addr SHALL be head in IDLE when no request is pending (no undefined drive).

Reset
REQ-034 rst_n=0 at a clock edge SHALL force FSM=IDLE, head=0, tail=0, idx=0, key=0, pop_data=0, push_ack=push_dup=push_full=pop_ack=0, mem_we=0, busy=0, empty=1, regardless of state.
REQ-035 Reset mid-SCAN or mid-WRITE SHALL abort the operation with no ack and no write.

Verification
REQ-036 Reset, push 0x123456789A -> push_ack after 3 cycles, dup=0, full=0, tail=1, empty=0, memory[0]=0x123456789A.
REQ-037 Push A, B, then A again -> third push_ack has push_dup=1, tail stays 2, no mem_we pulse.
REQ-038 Store A, B; pop twice -> pop_data=A then B, each 1 cycle after request; empty=1; third pop gives no pop_ack; pushing A again still returns dup=1.
REQ-039 Push 256 distinct states, then a 257th -> push_full=1, no mem_we, tail=256.
REQ-040 push_req and pop_req both high with one stored entry -> pop_ack first, push accepted next cycle, completes normally.
REQ-041 rst_n low during SCAN with tail=5 -> next cycle busy=0, tail=0, no push_ack, empty=1.
